// File: rtl/execute_stage_operand_fifo.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_operand_fifo
// Purpose  : Decode->execute operand bundle queue with valid/ready on both
//            sides, synchronous flush and optional empty fall-through.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage_operand_fifo #(
    parameter int XLEN        = 32,
    parameter int CTRL_W      = 16,
    parameter int DEPTH       = 4,
    parameter int FALLTHROUGH = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_data1,
    input  logic [XLEN-1:0]            in_data2,
    input  logic [XLEN-1:0]            in_imm,
    input  logic [CTRL_W-1:0]          in_control,
    input  logic                       in_compflg,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_data1,
    output logic [XLEN-1:0]            out_data2,
    output logic [XLEN-1:0]            out_imm,
    output logic [CTRL_W-1:0]          out_control,
    output logic                       out_compflg,
    output logic [XLEN-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = 4 * XLEN + CTRL_W + 1;
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] c_AF   = CW'(DEPTH - 1);

    logic [BW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [BW-1:0] w_in_bundle;
    logic [BW-1:0] w_head;
    logic [BW-1:0] w_sel;
    logic [BW-1:0] w_out_bundle;
    logic          w_empty;
    logic          w_ft;
    logic          w_push;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_rd_en;

    assign w_in_bundle = {in_pc, in_compflg, in_control, in_imm, in_data2, in_data1};
    assign w_head      = r_mem[r_rd_ptr];
    assign w_empty     = (r_count == '0);

    // Fall-through is masked during reset and flush so out_valid stays low then.
    generate
        if (FALLTHROUGH != 0) begin : g_ft
            assign w_ft = w_empty & in_valid & rst_n & ~flush;
        end else begin : g_no_ft
            assign w_ft = 1'b0;
        end
    endgenerate

    assign in_ready    = (r_count != c_FULL);
    assign out_valid   = ~flush & (~w_empty | w_ft);
    assign almost_full = (r_count >= c_AF);
    assign count       = r_count;

    assign w_push  = in_valid & in_ready;
    assign w_pop   = out_valid & out_ready;
    // A fall-through bundle consumed in the same cycle never touches storage.
    assign w_wr_en = w_push & ~flush & ~(w_ft & out_ready);
    assign w_rd_en = w_pop & ~w_ft;

    assign w_sel        = w_ft ? w_in_bundle : w_head;
    assign w_out_bundle = out_valid ? w_sel : '0;
    assign {out_pc, out_compflg, out_control, out_imm, out_data2, out_data1} = w_out_bundle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_en && !w_rd_en)      r_count <= r_count + 1'b1;
            else if (!w_wr_en && w_rd_en) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_in_bundle;
    end

endmodule
`default_nettype wire
